lpf_gear_ctrl: RTL and testbench
================================

// Module: lpf_gear_ctrl
// PURPOSE
//  Digital sequencer for the PLL charge-pump/2nd-order passive loop filter. Precharges the
//  filter output, runs wide-bandwidth acquisition (high Icp, low R), gear-shifts Icp down
//  to the tracking value, then holds lock. Relocks on loss of lock. Sits between the PLL
//  lock detector and the charge-pump current DAC / loop-filter R-select switch.
// PARAMETERS
//  CNT_W      16  width of internal cycle counters
//  ICP_W      4   width of charge-pump current code
//  PRECH_CYC  16  cycles precharge is held asserted
//  ACQ_MIN    256 minimum cycles spent in ACQ before lock qualification counts
//  LOCK_CNT   64  consecutive near_lock cycles needed to leave ACQ
//  STEP_CYC   32  cycles between Icp gear steps
//  ICP_ACQ    15  Icp code during acquisition
//  ICP_TRK    3   Icp code during tracking (ICP_TRK <= ICP_ACQ)
//  ICP_STEP   4   Icp decrement per gear step
//  UNLOCK_CNT 8   consecutive ~near_lock cycles that declare loss of lock
// PORTS
//  clk        in  1     reference-rate clock
//  rstn       in  1     asynchronous active-low reset
//  en         in  1     loop enable; low forces IDLE
//  near_lock  in  1     lock-detector flag, phase error within window this cycle
//  prech      out 1     drive filter node to initial voltage
//  icp_code   out ICP_W charge-pump current code
//  r_sel      out 1     0 = acquisition (low) R, 1 = tracking R
//  locked     out 1     loop declared locked
//  state      out 3     IDLE=0 PRECH=1 ACQ=2 GEAR=3 TRACK=4
// BEHAVIOUR
//  Reset (rstn=0, async): state=IDLE, prech=0, icp_code=0, r_sel=0, locked=0, counters=0.
//  All outputs registered; they change on the clk edge that enters a state.
//  IDLE : icp=0, r_sel=0. en=1 -> PRECH.
//  PRECH: prech=1, icp=0. After exactly PRECH_CYC cycles in PRECH -> ACQ (prech=0).
//  ACQ  : icp=ICP_ACQ, r_sel=0. Dwell counter counts to ACQ_MIN, saturates.
//         lock counter: +1 on near_lock, cleared on ~near_lock, saturates at LOCK_CNT.
//         Lock counter is held at 0 until dwell reaches ACQ_MIN.
//         lock counter == LOCK_CNT -> GEAR.
//  GEAR : r_sel=1 on entry. Every STEP_CYC cycles icp -= ICP_STEP, clamped at ICP_TRK
//         (no underflow/wrap). Edge that writes icp==ICP_TRK -> TRACK next cycle.
//         UNLOCK_CNT consecutive ~near_lock -> ACQ (icp=ICP_ACQ, r_sel=0, counters cleared).
//  TRACK: icp=ICP_TRK, r_sel=1, locked=1. UNLOCK_CNT consecutive ~near_lock ->
//         ACQ, locked=0 on same edge. Any near_lock clears the unlock counter.
//  en=0 in any state -> IDLE on next edge, all outputs to reset values; overrides others.
//  en toggled low then high restarts from PRECH (full precharge).
//  Unlock check takes priority over gear step on the same edge.
//  Counters saturate, never wrap. ICP_ACQ==ICP_TRK: GEAR exits after first STEP_CYC.
// TESTING
//  1 reset: rstn=0 mid-TRACK -> immediately state=0, icp=0, locked=0, prech=0.
//  2 en=1, near_lock=1 always -> prech 16 cyc; ACQ icp=15 for 256+64 cyc; GEAR icp
//    15->11->7->3 every 32 cyc; TRACK locked=1 icp=3 r_sel=1.
//  3 ACQ: near_lock drops once at lock count 63 -> counter restarts, 64 more cyc needed.
//  4 TRACK: 7 ~near_lock then 1 near_lock -> stays locked; 8 consecutive -> ACQ,
//    locked=0, icp=15, r_sel=0.
//  5 GEAR with icp=7: 8 ~near_lock -> ACQ, icp=15; clamp check ICP_STEP=5: 15->10->5->3.
//  6 en=0 for one cycle during GEAR -> IDLE; en=1 -> PRECH 16 cyc, full sequence repeats.

Source files
------------

// File: rtl/lpf_gear_ctrl_if.sv
// Control/status bundle between the loop sequencer, the lock detector and the CP/filter controls.
// Master drives enable and the lock flag; the sequencer (slave) drives the analog controls.
interface lpf_gear_ctrl_if #(
  parameter int ICP_W = 4
);
  logic             en;
  logic             near_lock;
  logic             prech;
  logic [ICP_W-1:0] icp_code;
  logic             r_sel;
  logic             locked;
  logic [2:0]       state;

  modport master (
    output en, near_lock,
    input  prech, icp_code, r_sel, locked, state
  );

  modport slave (
    input  en, near_lock,
    output prech, icp_code, r_sel, locked, state
  );
endinterface

// File: rtl/lpf_gear_ctrl.sv
// PLL loop-filter sequencer: precharge, wide-band acquisition, Icp gear-down, tracking, relock.
// All outputs registered (change on the edge entering a state); no backpressure, en=0 always wins.
module lpf_gear_ctrl #(
  parameter int CNT_W      = 16,
  parameter int ICP_W      = 4,
  parameter int PRECH_CYC  = 16,
  parameter int ACQ_MIN    = 256,
  parameter int LOCK_CNT   = 64,
  parameter int STEP_CYC   = 32,
  parameter int ICP_ACQ    = 15,
  parameter int ICP_TRK    = 3,
  parameter int ICP_STEP   = 4,
  parameter int UNLOCK_CNT = 8
) (
  input  logic           clk,
  input  logic           rstn,
  lpf_gear_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRECH = 3'd1,
    S_ACQ   = 3'd2,
    S_GEAR  = 3'd3,
    S_TRACK = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] PRECH_LAST = CNT_W'(PRECH_CYC - 1);
  localparam logic [CNT_W-1:0] ACQ_MIN_C  = CNT_W'(ACQ_MIN);
  localparam logic [CNT_W-1:0] LOCK_C     = CNT_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0] STEP_LAST  = CNT_W'(STEP_CYC - 1);
  localparam logic [CNT_W-1:0] UNL_C      = CNT_W'(UNLOCK_CNT);
  localparam logic [ICP_W-1:0] ICP_ACQ_C  = ICP_W'(ICP_ACQ);
  localparam logic [ICP_W-1:0] ICP_TRK_C  = ICP_W'(ICP_TRK);
  localparam logic [ICP_W-1:0] ICP_STEP_C = ICP_W'(ICP_STEP);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] lock_q, lock_d;
  logic [CNT_W-1:0] unl_q, unl_d;
  logic [CNT_W-1:0] unl_nxt;
  logic             prech_q, prech_d;
  logic             r_sel_q, r_sel_d;
  logic             locked_q, locked_d;
  logic [ICP_W-1:0] icp_q, icp_d;
  logic [ICP_W-1:0] icp_step;
  logic             step_fire;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      tmr_q    <= '0;
      lock_q   <= '0;
      unl_q    <= '0;
      prech_q  <= 1'b0;
      r_sel_q  <= 1'b0;
      locked_q <= 1'b0;
      icp_q    <= '0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      lock_q   <= lock_d;
      unl_q    <= unl_d;
      prech_q  <= prech_d;
      r_sel_q  <= r_sel_d;
      locked_q <= locked_d;
      icp_q    <= icp_d;
    end
  end

  // tmr_q is reused per state: precharge length, ACQ dwell, and GEAR step interval.
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    lock_d    = lock_q;
    unl_d     = unl_q;
    step_fire = 1'b0;
    icp_step  = ((int'(icp_q) - ICP_STEP) <= ICP_TRK) ? ICP_TRK_C : icp_q - ICP_STEP_C;
    if (bus.near_lock)
      unl_nxt = '0;
    else if (unl_q < UNL_C)
      unl_nxt = unl_q + 1'b1;
    else
      unl_nxt = unl_q;

    case (state_q)
      S_IDLE: begin
        tmr_d  = '0;
        lock_d = '0;
        unl_d  = '0;
        if (bus.en) state_d = S_PRECH;
      end
      S_PRECH: begin
        if (tmr_q == PRECH_LAST) begin
          state_d = S_ACQ;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_ACQ: begin
        if (tmr_q < ACQ_MIN_C) tmr_d = tmr_q + 1'b1;
        if ((tmr_q < ACQ_MIN_C) || !bus.near_lock)
          lock_d = '0;
        else if (lock_q < LOCK_C)
          lock_d = lock_q + 1'b1;
        if (lock_d == LOCK_C) begin
          state_d = S_GEAR;
          tmr_d   = '0;
          lock_d  = '0;
          unl_d   = '0;
        end
      end
      S_GEAR: begin
        unl_d = unl_nxt;
        if (unl_nxt == UNL_C) begin
          state_d = S_ACQ;
          tmr_d   = '0;
          lock_d  = '0;
          unl_d   = '0;
        end else if (tmr_q == STEP_LAST) begin
          step_fire = 1'b1;
          tmr_d     = '0;
          if (icp_step == ICP_TRK_C) state_d = S_TRACK;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_TRACK: begin
        unl_d = unl_nxt;
        if (unl_nxt == UNL_C) begin
          state_d = S_ACQ;
          tmr_d   = '0;
          lock_d  = '0;
          unl_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        tmr_d   = '0;
        lock_d  = '0;
        unl_d   = '0;
      end
    endcase

    if (!bus.en) begin
      state_d   = S_IDLE;
      tmr_d     = '0;
      lock_d    = '0;
      unl_d     = '0;
      step_fire = 1'b0;
    end
  end

  always_comb begin
    prech_d  = (state_d == S_PRECH);
    r_sel_d  = (state_d == S_GEAR) || (state_d == S_TRACK);
    locked_d = (state_d == S_TRACK);
    case (state_d)
      S_ACQ:   icp_d = ICP_ACQ_C;
      S_GEAR:  icp_d = step_fire ? icp_step : icp_q;
      S_TRACK: icp_d = ICP_TRK_C;
      default: icp_d = '0;
    endcase
  end

  assign bus.prech    = prech_q;
  assign bus.icp_code = icp_q;
  assign bus.r_sel    = r_sel_q;
  assign bus.locked   = locked_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_lpf_gear_ctrl.sv
// Bench for lpf_gear_ctrl: two instances (Icp step 4 and 5) share stimulus and are compared every
// cycle against a timeline model, with directed timing checks for lock, unlock, clamp and restart.
module tb_lpf_gear_ctrl;
  localparam int PRECH = 16, ACQ_MIN = 256, LOCK = 64, STEPC = 32;
  localparam int IACQ = 15, ITRK = 3, UNL = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic en_r = 1'b0;
  logic nl_r = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  // model: phase (0..4 as seen on the state port), time in phase, run lengths, current Icp
  int m_st[2], m_age[2], m_hi[2], m_lo[2], m_icp[2];

  lpf_gear_ctrl_if #(.ICP_W(4)) bif ();
  lpf_gear_ctrl_if #(.ICP_W(4)) bif5 ();

  assign bif.en         = en_r;
  assign bif.near_lock  = nl_r;
  assign bif5.en        = en_r;
  assign bif5.near_lock = nl_r;

  lpf_gear_ctrl dut (.clk(clk), .rstn(rstn), .bus(bif));
  lpf_gear_ctrl #(.ICP_STEP(5)) dut5 (.clk(clk), .rstn(rstn), .bus(bif5));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int stepv(input int k);
    return (k == 0) ? 4 : 5;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_age[k] = 0; m_hi[k] = 0; m_lo[k] = 0; m_icp[k] = 0;
    end
  endtask

  task automatic enter_acq(input int k);
    m_st[k] = 2; m_age[k] = 0; m_hi[k] = 0; m_lo[k] = 0; m_icp[k] = IACQ;
  endtask

  task automatic model_edge(input logic e, input logic n);
    for (int k = 0; k < 2; k++) begin
      if (!e) begin
        m_st[k] = 0; m_age[k] = 0; m_hi[k] = 0; m_lo[k] = 0; m_icp[k] = 0;
      end else begin
        case (m_st[k])
          0: begin m_st[k] = 1; m_age[k] = 0; end
          1: begin
            m_age[k]++;
            if (m_age[k] == PRECH) enter_acq(k);
          end
          2: begin
            if (m_age[k] >= ACQ_MIN) m_hi[k] = n ? m_hi[k] + 1 : 0;
            m_age[k]++;
            if (m_hi[k] == LOCK) begin
              m_st[k] = 3; m_age[k] = 0; m_lo[k] = 0;
            end
          end
          3: begin
            m_age[k]++;
            m_lo[k] = n ? 0 : m_lo[k] + 1;
            if (m_lo[k] == UNL) enter_acq(k);
            else if (m_age[k] % STEPC == 0) begin
              m_icp[k] = (m_icp[k] - stepv(k) < ITRK) ? ITRK : m_icp[k] - stepv(k);
              if (m_icp[k] == ITRK) m_st[k] = 4;
            end
          end
          default: begin
            m_lo[k] = n ? 0 : m_lo[k] + 1;
            if (m_lo[k] == UNL) enter_acq(k);
          end
        endcase
      end
    end
  endtask

  task automatic compare_all();
    logic [2:0] s;
    logic       p, r, l;
    logic [3:0] ic;
    int         exp_icp;
    for (int k = 0; k < 2; k++) begin
      s  = (k == 0) ? bif.state    : bif5.state;
      p  = (k == 0) ? bif.prech    : bif5.prech;
      r  = (k == 0) ? bif.r_sel    : bif5.r_sel;
      l  = (k == 0) ? bif.locked   : bif5.locked;
      ic = (k == 0) ? bif.icp_code : bif5.icp_code;
      exp_icp = (m_st[k] == 2) ? IACQ : (m_st[k] >= 3) ? m_icp[k] : 0;
      chk($sformatf("u%0d_state", k), 32'(s), m_st[k]);
      chk($sformatf("u%0d_prech", k), 32'(p), 32'(m_st[k] == 1));
      chk($sformatf("u%0d_r_sel", k), 32'(r), 32'(m_st[k] >= 3));
      chk($sformatf("u%0d_locked", k), 32'(l), 32'(m_st[k] == 4));
      chk($sformatf("u%0d_icp", k), 32'(ic), exp_icp);
    end
  endtask

  task automatic cyc(input logic e, input logic n);
    @(negedge clk);
    en_r = e;
    nl_r = n;
    @(posedge clk);
    #1;
    model_edge(e, n);
    compare_all();
  endtask

  task automatic cycn(input int cnt, input logic e, input logic n);
    for (int i = 0; i < cnt; i++) cyc(e, n);
  endtask

  // From IDLE with en and near_lock held high: edge 1 enters PRECH, 17 ACQ, 337 GEAR, 433 TRACK.
  task automatic clean_lock(input string tag);
    int f_acq = -1, f_gear = -1, f_trk = -1, f_trk5 = -1;
    int f_i11 = -1, f_i7 = -1, f_i10 = -1, f_i5 = -1;
    int n_prech = 0;
    for (int i = 1; i <= 440; i++) begin
      cyc(1'b1, 1'b1);
      if (bif.prech) n_prech++;
      if (f_acq  < 0 && bif.state  == 3'd2) f_acq  = i;
      if (f_gear < 0 && bif.state  == 3'd3) f_gear = i;
      if (f_trk  < 0 && bif.state  == 3'd4) f_trk  = i;
      if (f_trk5 < 0 && bif5.state == 3'd4) f_trk5 = i;
      if (f_i11 < 0 && bif.icp_code  == 4'd11) f_i11 = i;
      if (f_i7  < 0 && bif.icp_code  == 4'd7)  f_i7  = i;
      if (f_i10 < 0 && bif5.icp_code == 4'd10) f_i10 = i;
      if (f_i5  < 0 && bif5.icp_code == 4'd5)  f_i5  = i;
    end
    chk({tag, "_prech_len"}, n_prech, PRECH);
    chk({tag, "_acq_edge"}, f_acq, 1 + PRECH);
    chk({tag, "_gear_edge"}, f_gear, 1 + PRECH + ACQ_MIN + LOCK);
    chk({tag, "_icp11_edge"}, f_i11, 337 + STEPC);
    chk({tag, "_icp7_edge"}, f_i7, 337 + 2 * STEPC);
    chk({tag, "_track_edge"}, f_trk, 337 + 3 * STEPC);
    chk({tag, "_s5_icp10_edge"}, f_i10, 337 + STEPC);
    chk({tag, "_s5_icp5_edge"}, f_i5, 337 + 2 * STEPC);
    chk({tag, "_s5_track_edge"}, f_trk5, 337 + 3 * STEPC);
    chk({tag, "_trk_icp"}, 32'(bif.icp_code), ITRK);
    chk({tag, "_trk_locked"}, 32'(bif.locked), 1);
  endtask

  initial begin
    int pct;
    logic e, n;
    model_reset();
    #12;
    compare_all();
    @(negedge clk);
    rstn = 1'b1;

    // clean acquisition through gear-down to tracking, both step sizes
    clean_lock("base");

    // asynchronous reset while tracking
    @(negedge clk);
    rstn = 1'b0;
    en_r = 1'b0;
    #1;
    model_reset();
    chk("rst_state", 32'(bif.state), 0);
    chk("rst_locked", 32'(bif.locked), 0);
    chk("rst_icp", 32'(bif.icp_code), 0);
    compare_all();
    @(negedge clk);
    rstn = 1'b1;

    // lock counter broken at 63 restarts the 64-cycle qualification
    cycn(336, 1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    cycn(63, 1'b1, 1'b1);
    chk("lockrestart_still_acq", 32'(bif.state), 2);
    cyc(1'b1, 1'b1);
    chk("lockrestart_gear", 32'(bif.state), 3);

    // loss of lock in GEAR at icp=7 (icp=5 with step 5)
    cycn(64, 1'b1, 1'b1);
    chk("gear_icp7", 32'(bif.icp_code), 7);
    chk("gear_s5_icp5", 32'(bif5.icp_code), 5);
    cycn(7, 1'b1, 1'b0);
    chk("gear_unl7_hold", 32'(bif.state), 3);
    cyc(1'b1, 1'b0);
    chk("gear_unl_acq", 32'(bif.state), 2);
    chk("gear_unl_icp", 32'(bif.icp_code), IACQ);
    chk("gear_unl_rsel", 32'(bif.r_sel), 0);

    // unlock lands on the same edge as a gear step: unlock wins
    cycn(320, 1'b1, 1'b1);
    cycn(24, 1'b1, 1'b1);
    cycn(8, 1'b1, 1'b0);
    chk("prio_state", 32'(bif.state), 2);
    chk("prio_icp", 32'(bif.icp_code), IACQ);

    // tracking: 7 misses then a hit keeps lock; 8 consecutive misses drop it
    cycn(320 + 96, 1'b1, 1'b1);
    chk("trk_entry", 32'(bif.state), 4);
    cycn(7, 1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    chk("trk_keep_state", 32'(bif.state), 4);
    chk("trk_keep_locked", 32'(bif.locked), 1);
    cycn(7, 1'b1, 1'b0);
    chk("trk_unl7", 32'(bif.locked), 1);
    cyc(1'b1, 1'b0);
    chk("trk_unl_state", 32'(bif.state), 2);
    chk("trk_unl_locked", 32'(bif.locked), 0);
    chk("trk_unl_icp", 32'(bif.icp_code), IACQ);
    chk("trk_unl_rsel", 32'(bif.r_sel), 0);

    // en pulse low during GEAR forces IDLE, then a full restart
    cyc(1'b0, 1'b1);
    cycn(350, 1'b1, 1'b1);
    chk("en_gear", 32'(bif.state), 3);
    cyc(1'b0, 1'b1);
    chk("en_idle_state", 32'(bif.state), 0);
    chk("en_idle_rsel", 32'(bif.r_sel), 0);
    chk("en_idle_icp", 32'(bif.icp_code), 0);
    clean_lock("restart");

    // randomized stretches: mostly-locked vs noisy detector, rare enable drops
    for (int b = 0; b < 40; b++) begin
      pct = ($urandom_range(0, 3) == 0) ? 40 : 2;
      for (int i = 0; i < 500; i++) begin
        n = ($urandom_range(0, 99) >= pct);
        e = ($urandom_range(0, 999) != 0);
        cyc(e, n);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
